// File: rtl/plot_grid_sink.sv
// Coarse cell-grid mirror of the pixel-plot stream: keeps the last colour per
// 10x10 cell, answers cell-colour queries and tracks the number of occupied cells.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweep writes BG to every cell, plot/qreq ignored, busy=1
// ST_RUN   | plot pipeline and query path active
module plot_grid_sink #(
    parameter int         XSCREEN = 160,
    parameter int         YSCREEN = 120,
    parameter int         CELL    = 10,
    parameter int         GW      = 16,
    parameter int         GH      = 12,
    parameter logic [2:0] BG      = 3'b000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear,
    input  logic       qreq,
    input  logic [3:0] qx,
    input  logic [3:0] qy,
    output logic       qvalid,
    output logic [2:0] qcolour,
    output logic [7:0] occ_count,
    output logic       busy,
    output logic       oob
);

    localparam int         DEPTH    = GW * GH;
    localparam logic [7:0] LP_XS    = 8'(XSCREEN);
    localparam logic [6:0] LP_YS    = 7'(YSCREEN);
    localparam logic [7:0] LP_CELLX = 8'(CELL);
    localparam logic [6:0] LP_CELLY = 7'(CELL);
    localparam logic [7:0] LP_GW    = 8'(GW);
    localparam logic [7:0] LP_GH    = 8'(GH);
    localparam logic [7:0] LP_LAST  = 8'(DEPTH - 1);
    localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_sweep;
    logic [2:0] r_ram [0:DEPTH-1];

    logic       r_s1_v;
    logic [7:0] r_s1_x;
    logic [6:0] r_s1_y;
    logic [2:0] r_s1_col;

    logic       r_s2_v;
    logic [7:0] r_s2_idx;
    logic [2:0] r_s2_col;

    logic       r_s3_v;
    logic [7:0] r_s3_idx;
    logic [2:0] r_s3_col;
    logic [2:0] r_s3_old;

    logic       r_q_v;
    logic       r_q_ok;
    logic [7:0] r_q_idx;

    logic       r_qvalid;
    logic [2:0] r_qcolour;
    logic [7:0] r_occ;
    logic       r_oob;

    logic       w_run;
    logic       w_flush;
    logic       w_inside;
    logic [7:0] w_cx;
    logic [6:0] w_cy;
    logic [7:0] w_idx;
    logic [2:0] w_s2_old;
    logic       w_commit;
    logic [7:0] w_q_idx;
    logic       w_q_ok;

    assign w_run    = (r_state == ST_RUN);
    assign w_flush  = !w_run || clear;
    assign w_inside = (r_s1_x < LP_XS) && (r_s1_y < LP_YS);
    assign w_cx     = r_s1_x / LP_CELLX;
    assign w_cy     = r_s1_y / LP_CELLY;
    assign w_idx    = ({1'b0, w_cy} * LP_GW) + w_cx;

    // S3 commits at the same edge S2 samples the old colour, so bypass RAM on a match
    assign w_s2_old = (r_s3_v && (r_s3_idx == r_s2_idx)) ? r_s3_col : r_ram[r_s2_idx];
    assign w_commit = r_s3_v && w_run && !clear;

    assign w_q_idx  = ({4'b0000, qy} * LP_GW) + {4'b0000, qx};
    assign w_q_ok   = ({4'b0000, qx} < LP_GW) && ({4'b0000, qy} < LP_GH);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
            r_sweep <= 8'd0;
        end else if (r_state == ST_CLEAR) begin
            if (r_sweep == LP_LAST) begin
                r_state <= ST_RUN;
                r_sweep <= 8'd0;
            end else begin
                r_sweep <= r_sweep + 8'd1;
            end
        end else if (clear) begin
            r_state <= ST_CLEAR;
            r_sweep <= 8'd0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (r_state == ST_CLEAR) begin
                r_ram[r_sweep] <= BG;
            end else if (w_commit) begin
                r_ram[r_s3_idx] <= r_s3_col;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_s1_v   <= 1'b0;
            r_s1_x   <= 8'd0;
            r_s1_y   <= 7'd0;
            r_s1_col <= 3'd0;
            r_s2_v   <= 1'b0;
            r_s2_idx <= 8'd0;
            r_s2_col <= 3'd0;
            r_s3_v   <= 1'b0;
            r_s3_idx <= 8'd0;
            r_s3_col <= 3'd0;
            r_s3_old <= 3'd0;
            r_oob    <= 1'b0;
        end else begin
            r_s1_v   <= plot && !w_flush;
            r_s1_x   <= x;
            r_s1_y   <= y;
            r_s1_col <= colour;

            r_s2_v   <= r_s1_v && w_inside && !w_flush;
            r_s2_idx <= w_idx;
            r_s2_col <= r_s1_col;
            if (r_s1_v && !w_inside && !w_flush) begin
                r_oob <= 1'b1;
            end

            r_s3_v   <= r_s2_v && !w_flush;
            r_s3_idx <= r_s2_idx;
            r_s3_col <= r_s2_col;
            r_s3_old <= w_s2_old;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_occ <= 8'd0;
        end else if (!w_run) begin
            r_occ <= 8'd0;
        end else if (w_commit) begin
            if ((r_s3_old == BG) && (r_s3_col != BG) && (r_occ < LP_DEPTH)) begin
                r_occ <= r_occ + 8'd1;
            end else if ((r_s3_old != BG) && (r_s3_col == BG) && (r_occ != 8'd0)) begin
                r_occ <= r_occ - 8'd1;
            end
        end
    end

    // Reading RAM one edge after acceptance picks up the write committed at that edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q_v     <= 1'b0;
            r_q_ok    <= 1'b0;
            r_q_idx   <= 8'd0;
            r_qvalid  <= 1'b0;
            r_qcolour <= 3'd0;
        end else begin
            r_q_v    <= qreq && w_run && !clear;
            r_q_ok   <= w_q_ok;
            r_q_idx  <= w_q_idx;
            r_qvalid <= r_q_v;
            if (r_q_v) begin
                r_qcolour <= r_q_ok ? r_ram[r_q_idx] : BG;
            end
        end
    end

    assign qvalid    = r_qvalid;
    assign qcolour   = r_qcolour;
    assign occ_count = r_occ;
    assign busy      = (r_state == ST_CLEAR);
    assign oob       = r_oob;

endmodule

// File: tb/tb_plot_grid_sink.sv
// Bench for plot_grid_sink: directed scenarios plus randomized plot bursts
// checked against a cell-array model of the screen.
module tb_plot_grid_sink;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] x = 8'd0;
    logic [6:0] y = 7'd0;
    logic [2:0] colour = 3'd0;
    logic       plot = 1'b0;
    logic       clear = 1'b0;
    logic       qreq = 1'b0;
    logic [3:0] qx = 4'd0;
    logic [3:0] qy = 4'd0;
    logic       qvalid;
    logic [2:0] qcolour;
    logic [7:0] occ_count;
    logic       busy;
    logic       oob;

    int tests = 0;
    int fails = 0;

    bit [2:0] m_grid [192];
    bit       m_oob;

    plot_grid_sink dut (
        .Clock(clk), .Reset(Reset), .x(x), .y(y), .colour(colour), .plot(plot),
        .clear(clear), .qreq(qreq), .qx(qx), .qy(qy), .qvalid(qvalid),
        .qcolour(qcolour), .occ_count(occ_count), .busy(busy), .oob(oob)
    );

    always #5 clk = ~clk;

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < 192; i++) if (m_grid[i] != 3'b000) n++;
        return n;
    endfunction

    function automatic bit [2:0] model_cell(input int cx, input int cy);
        if (cx >= 16 || cy >= 12) return 3'b000;
        return m_grid[cy * 16 + cx];
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < 192; i++) m_grid[i] = 3'b000;
    endtask

    task automatic model_plot(input int px, input int py, input bit [2:0] pc);
        if (px >= 160 || py >= 120) m_oob = 1'b1;
        else m_grid[(py / 10) * 16 + (px / 10)] = pc;
    endtask

    // one pixel per cycle; consecutive calls keep plot high back to back
    task automatic do_plot(input int px, input int py, input bit [2:0] pc);
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = pc;
        model_plot(px, py, pc);
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_query(input int cx, input int cy, output bit [2:0] col, output bit got);
        qreq = 1'b1; qx = 4'(cx); qy = 4'(cy);
        @(negedge clk);
        qreq = 1'b0;
        got = 1'b0; col = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (qvalid) begin
                got = 1'b1; col = qcolour; break;
            end
            @(negedge clk);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int cnt;
        bit [2:0] col;
        bit got;
        Reset = 1'b1;
        idle(2);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %0b expected 1", busy); end
        tests++; if (occ_count !== 8'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occ_count); end
        tests++; if (oob !== 1'b0) begin fails++; $display("FAIL reset_oob: got %0b expected 0", oob); end
        tests++; if (qvalid !== 1'b0) begin fails++; $display("FAIL reset_qvalid: got %0b expected 0", qvalid); end
        Reset = 1'b0;
        model_wipe(); m_oob = 1'b0;
        count_busy(cnt);
        tests++; if (cnt != 192) begin fails++; $display("FAIL reset_busy_len: got %0d expected 192", cnt); end
        do_query(15, 11, col, got);
        tests++; if (got !== 1'b1) begin fails++; $display("FAIL reset_query_valid: got %0b expected 1", got); end
        tests++; if (col !== 3'b000) begin fails++; $display("FAIL reset_query_col: got %0b expected 000", col); end
    endtask

    task automatic test_block();
        bit [2:0] col;
        bit got;
        for (int py = 50; py < 60; py++)
            for (int px = 30; px < 40; px++)
                do_plot(px, py, 3'b010);
        idle(4);
        tests++; if (occ_count !== 8'(model_occ()) || occ_count !== 8'd1) begin fails++; $display("FAIL block_occ: got %0d expected 1", occ_count); end
        do_query(3, 5, col, got);
        tests++; if (!got || col !== 3'b010) begin fails++; $display("FAIL block_cell35: got %0b (valid %0b) expected 010", col, got); end
        do_query(4, 5, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL block_cell45: got %0b (valid %0b) expected 000", col, got); end
    endtask

    task automatic test_back_to_back();
        bit [2:0] col;
        bit got;
        for (int py = 50; py < 60; py++)
            for (int px = 30; px < 40; px++)
                do_plot(px, py, 3'b000);
        idle(4);
        tests++; if (occ_count !== 8'd0) begin fails++; $display("FAIL replot_bg_occ: got %0d expected 0", occ_count); end
        do_plot(80, 60, 3'b100);
        do_plot(81, 60, 3'b000);
        idle(4);
        do_query(8, 6, col, got);
        tests++; if (!got || col !== model_cell(8, 6)) begin fails++; $display("FAIL b2b_bg_cell: got %0b expected %0b", col, model_cell(8, 6)); end
        tests++; if (occ_count !== 8'(model_occ())) begin fails++; $display("FAIL b2b_bg_occ: got %0d expected %0d", occ_count, model_occ()); end
        do_plot(85, 65, 3'b101);
        do_plot(84, 61, 3'b011);
        do_plot(89, 69, 3'b110);
        idle(4);
        do_query(8, 6, col, got);
        tests++; if (!got || col !== model_cell(8, 6)) begin fails++; $display("FAIL b2b_triple_cell: got %0b expected %0b", col, model_cell(8, 6)); end
        tests++; if (occ_count !== 8'(model_occ())) begin fails++; $display("FAIL b2b_triple_occ: got %0d expected %0d", occ_count, model_occ()); end
    endtask

    task automatic test_oob();
        bit [2:0] col;
        bit got;
        int occ_before;
        occ_before = occ_count;
        do_plot(160, 0, 3'b111);
        do_plot(0, 120, 3'b111);
        idle(4);
        tests++; if (oob !== 1'b1) begin fails++; $display("FAIL oob_flag: got %0b expected 1", oob); end
        tests++; if (occ_count !== 8'(occ_before)) begin fails++; $display("FAIL oob_occ: got %0d expected %0d", occ_count, occ_before); end
        do_query(0, 0, col, got);
        tests++; if (!got || col !== model_cell(0, 0)) begin fails++; $display("FAIL oob_cell00: got %0b expected %0b", col, model_cell(0, 0)); end
        do_plot(159, 119, 3'b111);
        idle(4);
        do_query(15, 11, col, got);
        tests++; if (!got || col !== 3'b111) begin fails++; $display("FAIL edge_cell1511: got %0b expected 111", col); end
        do_query(16, 0, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL query_qx16: got %0b expected 000", col); end
        do_query(0, 12, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL query_qy12: got %0b expected 000", col); end
        tests++; if (oob !== 1'b1 || occ_count !== 8'(model_occ())) begin fails++; $display("FAIL oob_sticky: oob %0b occ %0d expected 1 / %0d", oob, occ_count, model_occ()); end
    endtask

    task automatic test_clear();
        int cnt;
        bit [2:0] col;
        bit got;
        bit seen_qvalid;
        do_plot(0, 0, 3'b101);
        do_plot(155, 115, 3'b011);
        idle(4);
        tests++; if (occ_count !== 8'(model_occ())) begin fails++; $display("FAIL preclear_occ: got %0d expected %0d", occ_count, model_occ()); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_wipe();
        cnt = 0; seen_qvalid = 1'b0;
        while (busy && cnt < 400) begin
            cnt++;
            if (qvalid) seen_qvalid = 1'b1;
            qreq = 1'b1; qx = 4'(cnt % 16); qy = 4'(cnt % 12);
            @(negedge clk);
        end
        qreq = 1'b0;
        repeat (3) begin
            if (qvalid) seen_qvalid = 1'b1;
            @(negedge clk);
        end
        tests++; if (cnt != 192) begin fails++; $display("FAIL clear_busy_len: got %0d expected 192", cnt); end
        tests++; if (seen_qvalid) begin fails++; $display("FAIL clear_qvalid: got 1 expected 0"); end
        tests++; if (occ_count !== 8'd0) begin fails++; $display("FAIL clear_occ: got %0d expected 0", occ_count); end
        do_query(0, 0, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL clear_cell00: got %0b expected 000", col); end
        do_query(15, 11, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL clear_cell1511: got %0b expected 000", col); end
        tests++; if (oob !== 1'b1) begin fails++; $display("FAIL clear_keeps_oob: got %0b expected 1", oob); end
    endtask

    // plot at edge t, query cell (0,0) at edge t+k
    task automatic test_query_timing(input int k, input bit [2:0] pc);
        bit [2:0] exp;
        exp = (k >= 3) ? pc : m_grid[0];
        plot = 1'b1; x = 8'd5; y = 7'd5; colour = pc;
        qx = 4'd0; qy = 4'd0;
        if (k == 0) qreq = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            plot = 1'b0;
            if (i == k - 1) qreq = 1'b1;
        end
        @(negedge clk);
        plot = 1'b0; qreq = 1'b0;
        tests++; if (qvalid !== 1'b0) begin fails++; $display("FAIL qtime_k%0d_early: got %0b expected 0", k, qvalid); end
        @(negedge clk);
        tests++; if (qvalid !== 1'b1 || qcolour !== exp) begin fails++; $display("FAIL qtime_k%0d_resp: valid %0b col %0b expected 1 / %0b", k, qvalid, qcolour, exp); end
        @(negedge clk);
        tests++; if (qvalid !== 1'b0 || qcolour !== exp) begin fails++; $display("FAIL qtime_k%0d_hold: valid %0b col %0b expected 0 / %0b", k, qvalid, qcolour, exp); end
        model_plot(5, 5, pc);
        idle(4);
    endtask

    task automatic test_random(input int n);
        bit [2:0] col;
        bit got;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                int px, py;
                if ($urandom_range(0, 19) == 0) begin
                    px = $urandom_range(150, 255);
                    py = $urandom_range(110, 127);
                end else begin
                    px = $urandom_range(0, 39);
                    py = $urandom_range(0, 29);
                end
                do_plot(px, py, 3'($urandom_range(0, 7)));
            end else begin
                idle(1);
            end
        end
        idle(4);
        tests++; if (occ_count !== 8'(model_occ())) begin fails++; $display("FAIL rand_occ: got %0d expected %0d", occ_count, model_occ()); end
        tests++; if (oob !== m_oob) begin fails++; $display("FAIL rand_oob: got %0b expected %0b", oob, m_oob); end
        for (int cy = 0; cy < 3; cy++)
            for (int cx = 0; cx < 4; cx++) begin
                do_query(cx, cy, col, got);
                tests++; if (!got || col !== model_cell(cx, cy)) begin fails++; $display("FAIL rand_cell_%0d_%0d: got %0b (valid %0b) expected %0b", cx, cy, col, got, model_cell(cx, cy)); end
            end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        bit [2:0] col;
        bit got;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        idle(50);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        model_wipe(); m_oob = 1'b0;
        tests++; if (oob !== 1'b0 || occ_count !== 8'd0) begin fails++; $display("FAIL rst_mid_flags: oob %0b occ %0d expected 0 / 0", oob, occ_count); end
        count_busy(cnt);
        tests++; if (cnt != 192) begin fails++; $display("FAIL rst_mid_busy_len: got %0d expected 192", cnt); end
        do_query(1, 1, col, got);
        tests++; if (!got || col !== 3'b000) begin fails++; $display("FAIL rst_mid_cell11: got %0b expected 000", col); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_block();
        test_back_to_back();
        test_oob();
        test_clear();
        test_query_timing(3, 3'b001);
        do_plot(5, 5, 3'b000);
        idle(4);
        test_query_timing(2, 3'b001);
        test_query_timing(0, 3'b110);
        test_query_timing(4, 3'b000);
        test_random(300);
        test_random(300);
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
